// File: rtl/memory_arbiter.sv
// Round-robin arbiter for the shared external memory port. Owners keep the port
// while their request stays high; a turnaround gap separates successive owners.
module memory_arbiter #(
  parameter int N          = 5,
  parameter int MAX_HOLD   = 16,
  parameter int TURNAROUND = 1,
  localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  input  logic [N-1:0]  i_Request,
  output logic [N-1:0]  o_Grant,
  output logic [IW-1:0] o_Grant_Index,
  output logic          o_Grant_Valid,
  output logic          o_Yield,
  output logic          o_Bus_Busy
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [IW:0]   NUM_REQ   = (IW+1)'(N);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURNAROUND - 1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] tenure_q, tenure_d;
  logic [TW-1:0] turn_q, turn_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          valid_q, valid_d;
  logic          yield_q, yield_d;
  logic          busy_q, busy_d;

  logic [IW:0]   candSum;
  logic [IW-1:0] candIdx;
  logic          pickValid;
  logic [IW-1:0] pickIdx;
  logic          othersReq;

  // Scan downward so the requester closest to the pointer is the last writer.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    candSum   = '0;
    candIdx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      candSum = {1'b0, ptr_q} + (IW+1)'(i);
      if (candSum >= NUM_REQ) candSum = candSum - NUM_REQ;
      candIdx = candSum[IW-1:0];
      if (i_Request[candIdx]) begin
        pickValid = 1'b1;
        pickIdx   = candIdx;
      end
    end
  end

  assign othersReq = |(i_Request & ~grant_q);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    tenure_d = tenure_q;
    turn_d   = turn_q;
    grant_d  = grant_q;
    valid_d  = valid_q;
    yield_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pickValid) begin
          state_d  = GRANT;
          owner_d  = pickIdx;
          grant_d  = N'(1) << pickIdx;
          valid_d  = 1'b1;
          tenure_d = '0;
        end
      end
      GRANT: begin
        if (i_Request[owner_q]) begin
          if (tenure_q < HOLD_MAX) tenure_d = tenure_q + 1'b1;
          yield_d = (MAX_HOLD != 0) && (tenure_q >= HOLD_MAX) && othersReq;
        end else begin
          state_d = RELEASE;
          grant_d = '0;
          valid_d = 1'b0;
          turn_d  = '0;
          ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        end
      end
      RELEASE: begin
        if (turn_q == TURN_LAST) state_d = IDLE;
        else                     turn_d  = turn_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      tenure_q <= '0;
      turn_q   <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      yield_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      tenure_q <= tenure_d;
      turn_q   <= turn_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      yield_q  <= yield_d;
      busy_q   <= busy_d;
    end
  end

  assign o_Grant       = grant_q;
  assign o_Grant_Index = owner_q;
  assign o_Grant_Valid = valid_q;
  assign o_Yield       = yield_q;
  assign o_Bus_Busy    = busy_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: vector table for single-cycle behaviour plus
// hand-written sequences for round-robin, yield, async reset and random fairness.
module tb_memory_arbiter;

  localparam int N = 5;

  logic         i_Clock;
  logic         i_Reset;
  logic [N-1:0] i_Request;
  logic [N-1:0] o_Grant;
  logic [2:0]   o_Grant_Index;
  logic         o_Grant_Valid;
  logic         o_Yield;
  logic         o_Bus_Busy;

  int totalChecks;
  int passChecks;

  typedef struct {
    logic [4:0] req;
    logic [4:0] grant;
    logic [2:0] idx;
    logic       valid;
    logic       yield;
    logic       busy;
  } vec_t;

  vec_t vecs[26];

  memory_arbiter #(.N(N), .MAX_HOLD(16), .TURNAROUND(1)) dut (
    .i_Clock      (i_Clock),
    .i_Reset      (i_Reset),
    .i_Request    (i_Request),
    .o_Grant      (o_Grant),
    .o_Grant_Index(o_Grant_Index),
    .o_Grant_Valid(o_Grant_Valid),
    .o_Yield      (o_Yield),
    .o_Bus_Busy   (o_Bus_Busy)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual === expected) passChecks++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  // Drive request mid-cycle, let one rising edge sample it, observe just after.
  task automatic applyStimulus(input logic [4:0] req);
    @(negedge i_Clock);
    i_Request = req;
    @(posedge i_Clock);
    #1;
  endtask

  task automatic resetDut();
    @(negedge i_Clock);
    i_Request = '0;
    i_Reset   = 1'b1;
    @(negedge i_Clock);
    i_Reset   = 1'b0;
  endtask

  task automatic runRandom(input int cycles);
    logic [4:0] req;
    int holdLen[N];
    int holdCnt[N];
    int waitT[N];
    logic prevValid;
    int errOneHot;
    int errReq;
    int errStarve;
    req = '0;
    prevValid = 1'b0;
    errOneHot = 0;
    errReq = 0;
    errStarve = 0;
    for (int i = 0; i < N; i++) begin
      holdLen[i] = 1;
      holdCnt[i] = 0;
      waitT[i]   = 0;
    end
    for (int c = 0; c < cycles; c++) begin
      applyStimulus(req);
      if (!$onehot0(o_Grant) || (o_Grant_Valid != (|o_Grant))) errOneHot++;
      if (o_Grant_Valid && (o_Grant != (5'b00001 << o_Grant_Index))) errOneHot++;
      if ((o_Grant & ~req) != 5'b00000) errReq++;
      if (o_Grant_Valid && !prevValid) begin
        for (int i = 0; i < N; i++) begin
          if (o_Grant[i]) waitT[i] = 0;
          else if (req[i]) begin
            waitT[i]++;
            if (waitT[i] > N - 1) errStarve++;
          end
        end
      end
      prevValid = o_Grant_Valid;
      for (int i = 0; i < N; i++) begin
        if (o_Grant[i]) begin
          holdCnt[i]++;
          if (holdCnt[i] >= holdLen[i]) req[i] = 1'b0;
        end else if (!req[i] && ($urandom_range(2) == 0)) begin
          req[i]     = 1'b1;
          holdLen[i] = int'($urandom_range(4, 1));
          holdCnt[i] = 0;
          waitT[i]   = 0;
        end
      end
    end
    checkOutput("rand_onehot", errOneHot, 0);
    checkOutput("rand_grant_without_req", errReq, 0);
    checkOutput("rand_starvation", errStarve, 0);
  endtask

  initial begin
    logic [4:0] reqV;
    int e;
    int yieldSeen;
    totalChecks = 0;
    passChecks  = 0;

    vecs[0]  = '{5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{5'b00100, 5'b00100, 3'd2, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{5'b00100, 5'b00100, 3'd2, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{5'b00100, 5'b00100, 3'd2, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{5'b00100, 5'b00100, 3'd2, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{5'b00000, 5'b00000, 3'd2, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{5'b00000, 5'b00000, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{5'b00000, 5'b00000, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{5'b00101, 5'b00001, 3'd0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{5'b00101, 5'b00001, 3'd0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{5'b00100, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{5'b00100, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{5'b00100, 5'b00100, 3'd2, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{5'b00000, 5'b00000, 3'd2, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{5'b00100, 5'b00000, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{5'b00100, 5'b00100, 3'd2, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{5'b00000, 5'b00000, 3'd2, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{5'b01000, 5'b00000, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{5'b00000, 5'b00000, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{5'b01010, 5'b01000, 3'd3, 1'b1, 1'b0, 1'b1};
    vecs[20] = '{5'b01010, 5'b01000, 3'd3, 1'b1, 1'b0, 1'b1};
    vecs[21] = '{5'b00010, 5'b00000, 3'd3, 1'b0, 1'b0, 1'b1};
    vecs[22] = '{5'b00010, 5'b00000, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[23] = '{5'b00010, 5'b00010, 3'd1, 1'b1, 1'b0, 1'b1};
    vecs[24] = '{5'b00000, 5'b00000, 3'd1, 1'b0, 1'b0, 1'b1};
    vecs[25] = '{5'b00000, 5'b00000, 3'd1, 1'b0, 1'b0, 1'b0};

    i_Reset   = 1'b1;
    i_Request = '0;
    #12;
    checkOutput("reset_grant", o_Grant, 5'b00000);
    checkOutput("reset_index", o_Grant_Index, 3'd0);
    checkOutput("reset_valid", o_Grant_Valid, 1'b0);
    checkOutput("reset_yield", o_Yield, 1'b0);
    checkOutput("reset_busy", o_Bus_Busy, 1'b0);
    @(negedge i_Clock);
    i_Reset = 1'b0;

    for (int v = 0; v < 26; v++) begin
      applyStimulus(vecs[v].req);
      checkOutput($sformatf("vec%0d_grant", v), o_Grant, vecs[v].grant);
      checkOutput($sformatf("vec%0d_index", v), o_Grant_Index, vecs[v].idx);
      checkOutput($sformatf("vec%0d_valid", v), o_Grant_Valid, vecs[v].valid);
      checkOutput($sformatf("vec%0d_yield", v), o_Yield, vecs[v].yield);
      checkOutput($sformatf("vec%0d_busy", v), o_Bus_Busy, vecs[v].busy);
    end

    // Everyone requesting, each owner holds two cycles: order 0,1,2,3,4,0.
    resetDut();
    reqV = 5'b11111;
    applyStimulus(reqV);
    for (int k = 0; k < 6; k++) begin
      e = k % N;
      checkOutput($sformatf("rr%0d_grant", k), o_Grant, 5'b00001 << e);
      checkOutput($sformatf("rr%0d_index", k), o_Grant_Index, e);
      applyStimulus(reqV);
      checkOutput($sformatf("rr%0d_hold", k), o_Grant, 5'b00001 << e);
      reqV[e] = 1'b0;
      applyStimulus(reqV);
      checkOutput($sformatf("rr%0d_drop", k), o_Grant, 5'b00000);
      reqV[e] = 1'b1;
      applyStimulus(reqV);
      checkOutput($sformatf("rr%0d_gap", k), o_Grant, 5'b00000);
      applyStimulus(reqV);
    end

    // Owner 1 holds past MAX_HOLD while 3 waits.
    resetDut();
    applyStimulus(5'b01010);
    checkOutput("yield_grant1", o_Grant, 5'b00010);
    for (int c = 1; c <= 19; c++) begin
      applyStimulus(5'b01010);
      checkOutput($sformatf("yield_c%0d", c), o_Yield, (c >= 17) ? 1'b1 : 1'b0);
    end
    checkOutput("yield_still_owner1", o_Grant, 5'b00010);
    applyStimulus(5'b01000);
    checkOutput("yield_drop_grant", o_Grant, 5'b00000);
    checkOutput("yield_drop_yield", o_Yield, 1'b0);
    applyStimulus(5'b01000);
    checkOutput("yield_gap", o_Grant, 5'b00000);
    applyStimulus(5'b01000);
    checkOutput("yield_next_owner", o_Grant, 5'b01000);
    checkOutput("yield_next_index", o_Grant_Index, 3'd3);
    checkOutput("yield_next_clear", o_Yield, 1'b0);

    // Lone requester 4 never sees yield; pointer wraps to 0 on release.
    resetDut();
    yieldSeen = 0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(5'b10000);
      if (o_Yield) yieldSeen++;
    end
    checkOutput("lone_yield_never", yieldSeen, 0);
    checkOutput("lone_grant4", o_Grant, 5'b10000);
    applyStimulus(5'b00000);
    applyStimulus(5'b00000);
    applyStimulus(5'b10001);
    checkOutput("wrap_grant0", o_Grant, 5'b00001);
    checkOutput("wrap_index0", o_Grant_Index, 3'd0);

    // Owner 2 granted with pointer at 3, then asynchronous reset mid-cycle.
    resetDut();
    applyStimulus(5'b00100);
    applyStimulus(5'b00000);
    applyStimulus(5'b00000);
    applyStimulus(5'b00100);
    checkOutput("areset_pre_grant", o_Grant, 5'b00100);
    #2;
    i_Reset = 1'b1;
    #1;
    checkOutput("areset_grant", o_Grant, 5'b00000);
    checkOutput("areset_valid", o_Grant_Valid, 1'b0);
    checkOutput("areset_busy", o_Bus_Busy, 1'b0);
    @(negedge i_Clock);
    i_Reset = 1'b0;
    applyStimulus(5'b01100);
    checkOutput("areset_ptr0_grant", o_Grant, 5'b00100);
    checkOutput("areset_ptr0_index", o_Grant_Index, 3'd2);

    resetDut();
    runRandom(10000);

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
